// File: rtl/keypad_pkg.sv
// keypad_pkg: shared event type, FSM states and default matrix geometry for the keypad scanner.
package keypad_pkg;
  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam int KEY_W = $clog2(KP_ROWS * KP_COLS);
  typedef struct packed {
    logic             long_p;
    logic [KEY_W-1:0] code;
  } kp_event_t;
  typedef enum logic [1:0] {IDLE, ARMING, HELD, LONG} kp_state_e;
endpackage

// File: rtl/kp_event_fifo.sv
// kp_event_fifo: first-word fall-through sync FIFO of key events; push while full is
// accepted only when a pop frees the head slot in the same cycle.
module kp_event_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  kp_event_t              i_data,
  input  logic                   i_pop,
  output kp_event_t              o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);
  kp_event_t r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign o_empty = r_count == '0;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_data = r_mem[r_rd];
  assign o_count = r_count;
  assign w_pop = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= (w_push && !w_pop) ? r_count + 1'b1 : (w_pop && !w_push) ? r_count - 1'b1 : r_count;
    end
endmodule

// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo: matrix keypad scanner with frame debounce and long-press detection,
// buffering key events in a FWFT FIFO read through a valid/ready handshake.
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int ROWS       = KP_ROWS,
  parameter int COLS       = KP_COLS,
  parameter int SCAN_DIV   = 1,
  parameter int DEBOUNCE   = 20,
  parameter int LONG_PRESS = 1000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        scan_en,
  input  logic [COLS-1:0]             col_in,
  output logic [ROWS-1:0]             row_out,
  output logic [KEY_W-1:0]            key_code,
  output logic                        key_long,
  output logic                        key_valid,
  input  logic                        key_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  input  logic                        overflow_clr
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2((LONG_PRESS > DEBOUNCE ? LONG_PRESS : DEBOUNCE) + 1);
  localparam int RL_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] DB_C = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] LP_C = CNT_W'(LONG_PRESS);
  localparam logic [RL_W-1:0] RL_C = RL_W'(DEBOUNCE);
  logic [DW-1:0] r_div;
  logic [RW-1:0] r_row;
  logic [RW-1:0] r_prow [3];
  logic [2:0] r_pv;
  logic [ROWS-1:0] r_row_out;
  logic [COLS-1:0] r_sync1, r_sync2;
  logic [1:0] r_acc_n;
  logic [KEY_W-1:0] r_acc_code;
  kp_state_e r_state;
  logic [KEY_W-1:0] r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [RL_W-1:0] r_rel;
  logic r_push;
  kp_event_t r_push_ev;
  logic w_last, w_frame, w_key, w_full, w_empty;
  logic [1:0] w_row_n, w_tot;
  logic [2:0] w_sum;
  logic [CW-1:0] w_col;
  logic [KEY_W-1:0] w_code;
  kp_event_t w_head;
  assign row_out = r_row_out;
  assign w_last = r_div == DW'(SCAN_DIV - 1);
  // Row sample happens 3 edges after the row's last drive slot: 1 for the row register, 2 for the synchroniser.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_div <= '0;
      r_row <= '0;
      r_row_out <= '1;
      r_pv <= '0;
      r_prow <= '{default: '0};
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= col_in;
      r_sync2 <= r_sync1;
      r_prow[0] <= r_row;
      r_prow[1] <= r_prow[0];
      r_prow[2] <= r_prow[1];
      if (!scan_en) begin
        r_div <= '0;
        r_row <= '0;
        r_row_out <= '1;
        r_pv <= '0;
      end else begin
        r_row_out <= ~(ROWS'(1) << r_row);
        r_div <= w_last ? '0 : r_div + 1'b1;
        if (w_last) r_row <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + 1'b1;
        r_pv <= {r_pv[1:0], w_last};
      end
    end
  always_comb begin
    w_row_n = '0;
    w_col = '0;
    for (int c = 0; c < COLS; c++)
      if (!r_sync2[c]) begin
        w_row_n = (w_row_n == 2'd2) ? 2'd2 : w_row_n + 2'd1;
        w_col = CW'(c);
      end
  end
  assign w_sum = {1'b0, r_acc_n} + {1'b0, w_row_n};
  assign w_tot = w_sum >= 3'd2 ? 2'd2 : w_sum[1:0];
  assign w_code = (w_row_n == 2'd1) ? KEY_W'(r_prow[2]) * KEY_W'(COLS) + KEY_W'(w_col) : r_acc_code;
  assign w_frame = r_pv[2] && r_prow[2] == RW'(ROWS - 1);
  assign w_key = w_tot == 2'd1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_acc_n <= '0;
      r_acc_code <= '0;
    end else if (!scan_en || w_frame) begin
      r_acc_n <= '0;
      r_acc_code <= '0;
    end else if (r_pv[2]) begin
      r_acc_n <= w_tot;
      r_acc_code <= w_code;
    end
  // Ghost frames (two or more keys) leave all debounce state untouched.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_cand <= '0;
      r_cnt <= '0;
      r_rel <= '0;
      r_push <= 1'b0;
      r_push_ev <= '0;
    end else begin
      r_push <= 1'b0;
      if (!scan_en) begin
        r_state <= IDLE;
        r_cnt <= '0;
        r_rel <= '0;
      end else if (w_frame && w_tot != 2'd2)
        case (r_state)
          IDLE:
            if (w_key) begin
              r_cand <= w_code;
              r_cnt <= CNT_W'(1);
              r_rel <= '0;
              r_state <= (DEBOUNCE <= 1) ? HELD : ARMING;
              r_push <= DEBOUNCE <= 1;
              r_push_ev <= '{long_p: 1'b0, code: w_code};
            end
          ARMING:
            if (!w_key) begin
              r_state <= IDLE;
              r_cnt <= '0;
            end else if (w_code != r_cand) begin
              r_cand <= w_code;
              r_cnt <= CNT_W'(1);
            end else begin
              r_cnt <= r_cnt + 1'b1;
              if (r_cnt + 1'b1 == DB_C) begin
                r_state <= HELD;
                r_push <= 1'b1;
                r_push_ev <= '{long_p: 1'b0, code: r_cand};
              end
            end
          default:
            if (!w_key) begin
              r_rel <= r_rel + 1'b1;
              if (r_rel + 1'b1 == RL_C) begin
                r_state <= IDLE;
                r_cnt <= '0;
                r_rel <= '0;
              end
            end else if (w_code == r_cand) begin
              r_rel <= '0;
              if (r_state == HELD) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt + 1'b1 == LP_C) begin
                  r_state <= LONG;
                  r_push <= 1'b1;
                  r_push_ev <= '{long_p: 1'b1, code: r_cand};
                end
              end
            end
        endcase
    end
  kp_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .i_rst_n (rst),
    .i_push  (r_push),
    .i_data  (r_push_ev),
    .i_pop   (key_ready),
    .o_data  (w_head),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  assign key_valid = !w_empty;
  assign key_code = key_valid ? w_head.code : '0;
  assign key_long = key_valid && w_head.long_p;
  always_ff @(posedge clk or negedge rst)
    if (!rst) overflow <= 1'b0;
    else if (overflow_clr) overflow <= 1'b0;
    else if (r_push && w_full && !key_ready) overflow <= 1'b1;
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// tb_keypad_scan_fifo: directed test of the keypad scanner against a key-matrix model,
// collecting popped events in a queue and comparing against hand-computed values.
module tb_keypad_scan_fifo;
  logic clk = 0, rst = 1, scan_en = 0, key_ready = 0, overflow_clr = 0;
  logic [3:0] col_in, row_out, key_code;
  logic key_long, key_valid, overflow;
  logic [2:0] fifo_count;
  logic [15:0] keys = '0;
  logic [4:0] evq [$];
  int n_total = 0, n_bad = 0;

  keypad_scan_fifo #(.ROWS(4), .COLS(4), .SCAN_DIV(2), .DEBOUNCE(3), .LONG_PRESS(10), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .col_in(col_in), .row_out(row_out),
    .key_code(key_code), .key_long(key_long), .key_valid(key_valid), .key_ready(key_ready),
    .fifo_count(fifo_count), .overflow(overflow), .overflow_clr(overflow_clr));

  always #5 clk = ~clk;

  always_comb begin
    col_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
  end

  always @(negedge clk)
    if (rst && key_valid && key_ready) evq.push_back({key_long, key_code});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ev(input int i);
    return i < evq.size() ? {27'd0, evq[i]} : 32'hdead;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic frames(input int n);
    cyc(n * 8);
  endtask

  task automatic press(input int k, input int hold);
    keys[k] = 1'b1;
    frames(hold);
    keys[k] = 1'b0;
    frames(5);
  endtask

  initial begin
    #1 rst = 0;
    cyc(3);
    chk("rst_row", row_out, 4'hf);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_long", key_long, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1;
    scan_en = 1;
    cyc(1);
    chk("row0_first", row_out, 4'he);

    key_ready = 1;
    press(9, 8);
    chk("t1_n", evq.size(), 1);
    chk("t1_ev", ev(0), {27'd0, 1'b0, 4'd9});
    evq.delete();

    for (int i = 0; i < 4; i++) begin
      keys[0] = 1'b1;
      frames(1);
      keys[0] = 1'b0;
      frames(1);
    end
    chk("t2_bounce", evq.size(), 0);
    press(0, 5);
    chk("t2_n", evq.size(), 1);
    chk("t2_ev", ev(0), 0);
    evq.delete();

    press(15, 12);
    chk("t3_n", evq.size(), 2);
    chk("t3_short", ev(0), {27'd0, 1'b0, 4'd15});
    chk("t3_long", ev(1), {27'd0, 1'b1, 4'd15});
    evq.delete();

    key_ready = 0;
    press(1, 5);
    press(2, 5);
    press(3, 5);
    press(4, 5);
    chk("t4_ovf_pre", overflow, 0);
    press(7, 5);
    chk("t4_count", fifo_count, 4);
    chk("t4_ovf", overflow, 1);
    chk("t4_head", key_code, 1);
    key_ready = 1;
    cyc(6);
    key_ready = 0;
    chk("t4_n", evq.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_ev%0d", i), ev(i), i + 1);
    chk("t4_sticky", overflow, 1);
    overflow_clr = 1;
    cyc(1);
    overflow_clr = 0;
    chk("t4_clr", overflow, 0);
    chk("t4_empty", fifo_count, 0);
    evq.delete();

    key_ready = 1;
    keys[5] = 1;
    keys[6] = 1;
    frames(6);
    chk("t5_ghost", evq.size(), 0);
    keys[6] = 0;
    frames(2);
    chk("t5_early", evq.size(), 0);
    frames(3);
    chk("t5_n", evq.size(), 1);
    chk("t5_ev", ev(0), 5);
    keys[5] = 0;
    frames(5);
    evq.delete();

    key_ready = 0;
    press(2, 5);
    chk("t6_queued", fifo_count, 1);
    keys[3] = 1;
    frames(1);
    rst = 0;
    cyc(2);
    chk("t6_row", row_out, 4'hf);
    chk("t6_count", fifo_count, 0);
    chk("t6_valid", key_valid, 0);
    keys = '0;
    rst = 1;
    frames(6);
    chk("t6_none", fifo_count, 0);

    keys[8] = 1;
    frames(5);
    chk("t7_queued", fifo_count, 1);
    scan_en = 0;
    cyc(1);
    chk("t7_row", row_out, 4'hf);
    frames(3);
    chk("t7_hold", fifo_count, 1);
    keys = '0;
    key_ready = 1;
    cyc(3);
    chk("t7_n", evq.size(), 1);
    chk("t7_ev", ev(0), 8);
    chk("t7_empty", key_valid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
